register_alu_integration: RTL and testbench



---
 rtl/rv32i_pkg.sv | 67 ++++++
 rtl/register_file.sv | 47 ++++
 rtl/register_alu_integration.sv | 97 +++++++++
 tb/tb_register_alu_integration.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath definitions: major opcodes, funct3/funct7 codes, ALU helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package rv32i_pkg;

  localparam int XLEN = 32;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  // ALU funct3 codes (shared by R-type and I-type)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch-condition funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 value selecting SUB / SRA / SRAI
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Bundled outputs of the datapath slice
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            branch;
    logic [XLEN-1:0] read_address;
    logic [XLEN-1:0] write_address;
  } alu_out_t;

  // Arithmetic/logic op selected by funct3. 'alt' picks SUB for funct3=000
  // and arithmetic right shift for funct3=101; the caller decides when alt
  // is legal (I-type never subtracts).
  function automatic logic [XLEN-1:0] alu_calc(
    input logic [2:0]      f3,
    input logic            alt,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [4:0] shamt;
    shamt = b[4:0];
    case (f3)
      F3_ADD:  alu_calc = alt ? (a - b) : (a + b);
      F3_SLL:  alu_calc = a << shamt;
      F3_SLT:  alu_calc = {31'b0, ($signed(a) < $signed(b))};
      F3_SLTU: alu_calc = {31'b0, (a < b)};
      F3_XOR:  alu_calc = a ^ b;
      F3_SR:   alu_calc = alt ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
      F3_OR:   alu_calc = a | b;
      default: alu_calc = a & b;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: one write port, two combinational read ports, x0 hardwired to zero.
// Latency: reads 0 cycles; a write becomes visible right after the clock edge (no bypass).
// Backpressure: none; a write is accepted every cycle it is strobed.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low clear of all registers
//   we, wa, wd      write strobe, destination index, write data
//   ra1/rd1, ra2/rd2  read index / read data for the two read ports
module register_file
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    // x0 is never written so it stays at its reset value of zero
    if (we && (wa != 5'd0)) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/register_alu_integration.sv
// RV32I integer slice: register file feeding a combinational ALU, branch comparator and load/store address generator.
// Latency: all outputs combinational (0 cycles) from inputs and register state; writes land on the rising edge.
// Backpressure: none; one operation evaluated continuously, one write per cycle.
//
// Ports:
//   clk, rst                     clock and asynchronous active-low reset
//   write_data, rd, writeEnable  writeback port
//   rs1, rs2                     source register indices -> register1, register2
//   ALU_source, immediate        operand B select (1 = immediate) and sign-extended immediate
//   opcode, funct3, funct7       decoded operation
//   result, branch               ALU result and branch-taken flag
//   read_address, write_address  data-memory load / store address
module register_alu_integration
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] write_data,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            writeEnable,
  input  logic            ALU_source,
  input  logic [6:0]      opcode,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] read_address,
  output logic [XLEN-1:0] write_address,
  output logic [XLEN-1:0] result,
  output logic            branch,
  output logic [XLEN-1:0] register1,
  output logic [XLEN-1:0] register2
);

  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] mem_addr;
  logic            f7_alt;
  alu_out_t        dp;

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .we  (writeEnable),
    .wa  (rd),
    .wd  (write_data),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (register1),
    .rd2 (register2)
  );

  assign operand_b = ALU_source ? immediate : register2;
  assign mem_addr  = register1 + immediate;
  assign f7_alt    = (funct7 == FUNCT7_ALT);

  always_comb begin
    dp = '0;
    case (opcode)
      OP_R: begin
        dp.result = alu_calc(funct3, f7_alt, register1, operand_b);
      end
      OP_I: begin
        // funct7 only matters for the right shift; there is no SUBI
        dp.result = alu_calc(funct3, f7_alt && (funct3 == F3_SR), register1, operand_b);
      end
      OP_BRANCH: begin
        // Branches always compare the two registers, whatever ALU_source says
        dp.result = register1 - register2;
        case (funct3)
          F3_BEQ:  dp.branch = (register1 == register2);
          F3_BNE:  dp.branch = (register1 != register2);
          F3_BLT:  dp.branch = ($signed(register1) <  $signed(register2));
          F3_BGE:  dp.branch = ($signed(register1) >= $signed(register2));
          F3_BLTU: dp.branch = (register1 <  register2);
          F3_BGEU: dp.branch = (register1 >= register2);
          default: dp.branch = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dp.result       = mem_addr;
        dp.read_address = mem_addr;
      end
      OP_STORE: begin
        dp.result        = mem_addr;
        dp.write_address = mem_addr;
      end
      default: dp = '0;
    endcase
  end

  assign result        = dp.result;
  assign branch        = dp.branch;
  assign read_address  = dp.read_address;
  assign write_address = dp.write_address;

endmodule

// File: tb/tb_register_alu_integration.sv
// Self-checking bench for register_alu_integration: directed cases plus random operations vs a reference model.
// Latency: checks combinational outputs half a cycle after inputs settle.
// Backpressure: n/a.
module tb_register_alu_integration;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] B_OP  = 7'b1100011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] ALT   = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] write_data = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic        writeEnable = 1'b0;
  logic        ALU_source = 1'b0;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] immediate = '0;
  logic [31:0] read_address, write_address, result, register1, register2;
  logic        branch;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_regs [32];

  register_alu_integration dut (
    .clk(clk), .rst(rst), .write_data(write_data), .rd(rd), .rs1(rs1), .rs2(rs2),
    .writeEnable(writeEnable), .ALU_source(ALU_source), .opcode(opcode),
    .funct7(funct7), .funct3(funct3), .immediate(immediate),
    .read_address(read_address), .write_address(write_address), .result(result),
    .branch(branch), .register1(register1), .register2(register2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written from the ISA rules with plain integer arithmetic.
  function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm,
                                input logic sel, output logic [31:0] res, output logic br,
                                output logic [31:0] ra, output logic [31:0] wa);
    logic [31:0] b;
    logic [63:0] ext;
    int sh;
    longint sa, sb;
    b = sel ? imm : r2;
    sh = int'(b % 32);
    res = 0; br = 0; ra = 0; wa = 0;
    if (op == R_OP || op == I_OP) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f3)
        3'd0: res = (op == R_OP && f7 == ALT) ? a + (~b + 32'd1) : a + b;
        3'd1: res = a * (32'd1 << sh);
        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: res = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: begin
          ext = (f7 == ALT && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
          ext = ext >> sh;
          res = ext[31:0];
        end
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end else if (op == B_OP) begin
      sa = longint'($signed(a));
      sb = longint'($signed(r2));
      res = a - r2;
      case (f3)
        3'd0: br = (a == r2);
        3'd1: br = (a != r2);
        3'd4: br = (sa < sb);
        3'd5: br = (sa >= sb);
        3'd6: br = ({32'b0, a} < {32'b0, r2});
        3'd7: br = ({32'b0, a} >= {32'b0, r2});
        default: br = 1'b0;
      endcase
    end else if (op == LD_OP) begin
      res = a + imm; ra = res;
    end else if (op == ST_OP) begin
      res = a + imm; wa = res;
    end
  endfunction

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    rd = idx; write_data = val; writeEnable = 1'b1;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    if (idx != 5'd0) model_regs[idx] = val;
  endtask

  task automatic exec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] imm, input logic sel);
    logic [31:0] e_res, e_ra, e_wa;
    logic        e_br;
    opcode = op; funct3 = f3; funct7 = f7; rs1 = s1; rs2 = s2;
    immediate = imm; ALU_source = sel;
    @(negedge clk);
    model(op, f3, f7, model_regs[s1], model_regs[s2], imm, sel, e_res, e_br, e_ra, e_wa);
    chk({tag, ".reg1"},   register1, model_regs[s1]);
    chk({tag, ".reg2"},   register2, model_regs[s2]);
    chk({tag, ".result"}, result, e_res);
    chk({tag, ".branch"}, {31'b0, branch}, {31'b0, e_br});
    chk({tag, ".raddr"},  read_address, e_ra);
    chk({tag, ".waddr"},  write_address, e_wa);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] ops [6];
    ops[0] = R_OP; ops[1] = I_OP; ops[2] = B_OP; ops[3] = LD_OP; ops[4] = ST_OP; ops[5] = 7'b1101111;
    for (int i = 0; i < 32; i++) model_regs[i] = '0;

    // Reset state
    #12;
    exec("reset", R_OP, 3'd0, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("reset_const_r1", register1, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic writes and reads
    wr(5'd1, 32'd1);
    wr(5'd2, 32'd1);
    exec("read_x0", R_OP, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    exec("add", R_OP, 3'd0, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("add_const", result, 32'd2);
    exec("sub", R_OP, 3'd0, ALT, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("sub_const", result, 32'd0);
    exec("xor", R_OP, 3'd4, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    exec("or",  R_OP, 3'd6, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    exec("and", R_OP, 3'd7, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);

    // I-type, including funct7=ALT on ADDI (must still add)
    exec("addi", I_OP, 3'd0, 7'd0, 5'd1, 5'd0, 32'd1, 1'b1);
    exec("addi_alt", I_OP, 3'd0, ALT, 5'd1, 5'd0, 32'd1, 1'b1);
    chk("addi_alt_const", result, 32'd2);
    exec("xori", I_OP, 3'd4, 7'd0, 5'd1, 5'd0, 32'd1, 1'b1);
    exec("ori",  I_OP, 3'd6, 7'd0, 5'd1, 5'd0, 32'd1, 1'b1);
    exec("andi", I_OP, 3'd7, 7'd0, 5'd1, 5'd0, 32'd1, 1'b1);

    // Shifts
    wr(5'd1, 32'h8000_0001);
    wr(5'd2, 32'd16);
    wr(5'd3, 32'd32);
    exec("slli1", I_OP, 3'd1, 7'd0, 5'd1, 5'd0, 32'd1, 1'b1);
    chk("slli1_const", result, 32'h0000_0002);
    exec("srl16", R_OP, 3'd5, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("srl16_const", result, 32'h0000_8000);
    exec("srai1", I_OP, 3'd5, ALT, 5'd1, 5'd0, 32'd1, 1'b1);
    chk("srai1_const", result, 32'hC000_0000);
    exec("sll32", R_OP, 3'd1, 7'd0, 5'd1, 5'd3, 32'd0, 1'b0);
    chk("sll32_const", result, 32'h8000_0001);

    // Branches
    wr(5'd1, 32'd5);
    wr(5'd2, 32'd5);
    exec("beq", B_OP, 3'd0, 7'd0, 5'd1, 5'd2, 32'd7, 1'b1);
    exec("bne", B_OP, 3'd1, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    wr(5'd1, 32'hFFFF_FFFF);
    wr(5'd2, 32'd1);
    exec("blt",  B_OP, 3'd4, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("blt_const", {31'b0, branch}, 32'd1);
    exec("bltu", B_OP, 3'd6, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    exec("bge",  B_OP, 3'd5, 7'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    exec("b010", B_OP, 3'd2, 7'd0, 5'd2, 5'd2, 32'd0, 1'b0);
    exec("nonbr", R_OP, 3'd0, 7'd0, 5'd2, 5'd2, 32'd0, 1'b0);
    exec("load",  LD_OP, 3'd2, 7'd0, 5'd2, 5'd0, 32'h100, 1'b0);
    exec("store", ST_OP, 3'd2, 7'd0, 5'd2, 5'd0, 32'hFFFF_FFF0, 1'b1);
    exec("other", 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd2, 32'h55, 1'b1);

    // x0 write discarded
    wr(5'd0, 32'hFFFF_FFFF);
    exec("x0_write", R_OP, 3'd6, 7'd0, 5'd0, 5'd0, 32'd0, 1'b0);

    // Random operations interleaved with random writes
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) wr(5'($urandom_range(0, 31)), pick_val());
      exec("rand", ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 1) ? ALT : 7'($urandom),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), pick_val(), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-cycle, with a write pending that must be dropped
    wr(5'd5, 32'hDEAD_BEEF);
    rs1 = 5'd5; rs2 = 5'd1;
    @(negedge clk);
    #2;
    rd = 5'd6; write_data = 32'h1234_5678; writeEnable = 1'b1;
    rst = 1'b0;
    #1;
    chk("async_rst_r1", register1, 32'd0);
    chk("async_rst_r2", register2, 32'd0);
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    rst = 1'b1;
    exec("post_rst", R_OP, 3'd0, 7'd0, 5'd6, 5'd5, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
